// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the block sum accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sum_acc_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LOG2_N = 2;
    // Accumulator width that holds N full-scale samples without overflow.
    localparam int ACC_W          = DEFAULT_DATA_W + DEFAULT_LOG2_N;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/sum_acc_max.sv
// Running maximum of the samples accepted in the current block.
// Latency: updates on the accepting edge; value visible next cycle.
// Backpressure: none, follows the accept strobe of the parent.
module sum_acc_max #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              first,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] max_val
);

    // First sample of a block loads unconditionally; later ones only if larger.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            max_val <= '0;
        end else if (load && (first || (sample > max_val))) begin
            max_val <= sample;
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates blocks of 2^LOG2_N samples and presents total and truncated mean
// (plus block maximum when SUM_ACC_MAX_EN is defined). Result registered on the
// edge accepting the Nth sample; input stalls (in_ready=0) until the result is taken.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LOG2_N = DEFAULT_LOG2_N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W+LOG2_N-1:0] out_sum,
`ifdef SUM_ACC_MAX_EN
    output logic [DATA_W-1:0]        out_max,
`endif
    output logic [DATA_W-1:0]        out_mean
);

    localparam int SUM_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_IDX = '1;

    state_t            state;
    logic [SUM_W-1:0]  acc;
    logic [LOG2_N-1:0] cnt;
    logic              accept;
    logic [SUM_W-1:0]  acc_next;

    // Ready depends only on state so the upstream never sees a valid->ready loop.
    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;
    // Sized so N full-scale samples fit; no wrap or saturation is possible.
    assign acc_next = acc + SUM_W'(in_data);

    // Block FSM: accumulate N samples, then hold the result until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_mean  <= '0;
        end else if (clear) begin
            // Abort wins over any same-cycle accept or output handshake.
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            out_sum   <= acc_next;
                            out_mean  <= acc_next[SUM_W-1:LOG2_N];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef SUM_ACC_MAX_EN
    logic first_sample;
    assign first_sample = (cnt == '0);

    sum_acc_max #(
        .DATA_W (DATA_W)
    ) u_max (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .load    (accept),
        .first   (first_sample),
        .sample  (in_data),
        .max_val (out_max)
    );
`endif

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator with a result scoreboard.
// Expected block results are queued as samples are driven and popped on out_valid.
// Optional out_max checks follow SUM_ACC_MAX_EN.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_sum;
    logic [7:0] out_mean;
`ifdef SUM_ACC_MAX_EN
    logic [7:0] out_max;
`endif

    typedef struct {
        int sum;
        int mean;
        int mx;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sum_accumulator #(
        .DATA_W (8),
        .LOG2_N (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef SUM_ACC_MAX_EN
        .out_max   (out_max),
`endif
        .out_mean  (out_mean)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int v);
        in_valid = 1'b1;
        in_data  = 8'(v);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input int a, input int b, input int c, input int d);
        exp_t e;
        e.sum  = a + b + c + d;
        e.mean = e.sum / 4;
        e.mx   = a;
        if (b > e.mx) e.mx = b;
        if (c > e.mx) e.mx = c;
        if (d > e.mx) e.mx = d;
        sb.push_back(e);
    endtask

    task automatic block(input int a, input int b, input int c, input int d);
        push_exp(a, b, c, d);
        put(a);
        put(b);
        put(c);
        put(d);
    endtask

    // Wait (bounded) for out_valid, then compare the result against the queue head.
    task automatic wait_result(input string tag);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                found = 1;
                break;
            end
            cyc();
        end
        if (!found) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, 32'd0, 32'd1);
        end else begin
            last = sb.pop_front();
            chk({tag, "_sum"}, 32'(out_sum), last.sum);
            chk({tag, "_mean"}, 32'(out_mean), last.mean);
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
`ifdef SUM_ACC_MAX_EN
            chk({tag, "_max"}, 32'(out_max), last.mx);
`endif
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_sum"}, 32'(out_sum), 32'd0);
        chk({tag, "_mean"}, 32'(out_mean), 32'd0);
`ifdef SUM_ACC_MAX_EN
        chk({tag, "_max"}, 32'(out_max), 32'd0);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state.
        chk_zero("reset");
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Basic block; result one cycle after the 4th accept; ready low for one cycle.
        block(10, 20, 30, 41);
        chk("basic_latency", 32'(out_valid), 32'd1);
        wait_result("basic");
        cyc();
        chk("basic_hs_valid", 32'(out_valid), 32'd0);
        chk("basic_hs_ready", 32'(in_ready), 32'd1);

        // Full-scale samples must not overflow.
        block(255, 255, 255, 255);
        wait_result("fullscale");
        cyc();

        // Backpressure: result held for 5 cycles, DONE-time input pulses ignored.
        out_ready = 1'b0;
        block(9, 9, 9, 9);
        wait_result("hold");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd200;
            cyc();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(out_sum), last.sum);
            chk("hold_mean", 32'(out_mean), last.mean);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("hold_release", 32'(out_valid), 32'd0);
        block(1, 1, 1, 1);
        wait_result("after_hold");
        cyc();

        // Input gaps leave the partial block untouched.
        push_exp(5, 6, 7, 8);
        put(5);
        cyc();
        cyc();
        put(6);
        cyc();
        chk("gap_midblock", 32'(out_valid), 32'd0);
        put(7);
        put(8);
        wait_result("gaps");
        cyc();

        // clear mid-block, with a simultaneous sample that must be dropped.
        put(50);
        put(60);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd100;
        cyc();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_mid_valid", 32'(out_valid), 32'd0);
        block(1, 2, 3, 4);
        wait_result("after_clear");
        cyc();

        // clear in DONE wins over a simultaneous out_ready.
        out_ready = 1'b0;
        block(7, 7, 7, 7);
        wait_result("clear_done");
        clear     = 1'b1;
        out_ready = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear_done_valid", 32'(out_valid), 32'd0);
        chk("clear_done_ready", 32'(in_ready), 32'd1);
        block(2, 2, 2, 2);
        wait_result("after_clear_done");
        cyc();

        // Reset mid-block discards partial data.
        put(9);
        put(9);
        put(9);
        rst = 1'b1;
        cyc();
        chk_zero("rst_mid");
        rst = 1'b0;
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        block(4, 4, 4, 4);
        wait_result("after_rst_mid");
        cyc();

        // Reset while a result is pending.
        out_ready = 1'b0;
        block(5, 5, 5, 5);
        wait_result("rst_done_pre");
        rst = 1'b1;
        cyc();
        chk_zero("rst_done");
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("rst_done_ready", 32'(in_ready), 32'd1);
        block(4, 4, 4, 4);
        wait_result("after_rst_done");
        cyc();
        chk("final_idle", 32'(out_valid), 32'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the operand adder: accepts a stream of 8-bit sums over a valid/ready handshake, accumulates a block of 2^LOG2_N samples, and presents the block total and truncated mean to the next stage over a second valid/ready handshake. It turns per-cycle adder results into block statistics for the output pins, or for a later readout stage.

## Interface
- DATA_W, 8, width of each incoming sum sample and of out_mean
- LOG2_N, 2, log2 of samples per block (N = 2^LOG2_N, LOG2_N >= 1)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous abort: discard the partial or pending block
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  DATA_W  sum sample from the adder
- out_valid  out  1  block result is valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  DATA_W+LOG2_N  exact total of N samples
- out_mean  out  DATA_W  out_sum >> LOG2_N (truncated)
- out_max  out  DATA_W  largest sample in block; present only with SUM_ACC_MAX_EN

## Operation
- States: ACCUM, DONE.
- ACCUM behaviour:
  - in_ready=1, out_valid=0.
  - Accept when in_valid&&in_ready: acc += in_data and cnt++.
  - If the accepted sample is the Nth (cnt==N-1): latch acc+in_data into out_sum, compute out_mean, go to DONE.
- DONE behaviour:
  - in_ready=0, out_valid=1; out_sum/out_mean/out_max held stable.
  - On out_ready: acc=0, cnt=0, go to ACCUM.
- Width rule: accumulator is DATA_W+LOG2_N bits and cannot overflow; no saturation or wrap logic.
- Gaps: in_valid low in ACCUM leaves acc and cnt unchanged, with no timeout.
- clear (any state): acc=0, cnt=0, state=ACCUM, out_valid=0 next cycle.
  - clear has priority over a simultaneous input accept and over a simultaneous output handshake. The result is dropped and the sample is not counted.
- rst has priority over clear. A reset mid-block discards all partial data.
- Reset values:
  - state=ACCUM, acc=0, cnt=0.
  - out_valid=0, out_sum=0, out_mean=0, out_max=0.
  - in_ready=1 in the first cycle after rst deasserts.

## Timing
- in_ready is decoded combinationally from state only and does not depend on in_valid. All other outputs are registered.
- Latency: out_valid rises on the clock edge that accepts the Nth sample; the result is visible the next cycle.
- Minimum block period: N accept cycles plus 1 DONE cycle (out_ready held high). Throughput is N/(N+1) samples per cycle.
- The output handshake completes on the edge where out_valid&&out_ready. in_ready returns high the following cycle.
- out_valid, once high, stays high with stable data until the handshake completes, clear is asserted, or rst is asserted.

## Configuration
- SUM_ACC_MAX_EN defined:
  - Adds the out_max port and a DATA_W max register.
  - The register is updated on every accept in ACCUM (first sample of a block loads it unconditionally).
  - The register is latched with out_sum, cleared by rst/clear, and held in DONE.
- SUM_ACC_MAX_EN undefined: no out_max port and no max register. All other behaviour is identical.

## Structure
- Shared package sum_acc_pkg:
  - State enum (ACCUM, DONE).
  - Default DATA_W and LOG2_N constants.
  - Helper constant ACC_W = DATA_W+LOG2_N.
- One sub-module, sum_acc_max: the running-max register, instantiated only under SUM_ACC_MAX_EN.
- FSM, counter and accumulator stay in sum_accumulator.

## Test plan
- Defaults, out_ready=1, samples 10,20,30,41 on consecutive cycles -> out_valid one cycle later; out_sum=101, out_mean=25, out_max=41 (macro on); in_ready=0 for exactly that cycle.
- Four samples of 255 -> out_sum=1020, out_mean=255; no overflow.
- out_ready low for 5 cycles after a block completes -> out_valid and data stable for all 5 cycles; in_ready=0; in_valid pulses during DONE are not counted. The next block of 1,1,1,1 yields out_sum=4.
- in_valid toggled with gaps (samples 5,gap,gap,6,gap,7,8) -> out_sum=26, out_mean=6.
- clear after two samples (50,60), then 1,2,3,4 -> out_sum=10. clear asserted in DONE together with out_ready -> out_valid=0 next cycle, no result consumed.
- rst asserted after three samples and again while in DONE -> all outputs are 0 the next cycle, in_ready=1 after release, and a fresh block of 4,4,4,4 gives out_sum=16.
